fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (fixed at 4; grant index is 2 bits).
REQ-002 The block SHALL have parameter W, default 8, giving the data width per requester.
REQ-003 The block SHALL have parameter BURST, default 4, giving the maximum pushes per grant (range 1..15).
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  N_REQ  per-requester data valid.
REQ-007 req_data  input  N_REQ*W  concatenated request data; requester i uses bits [i*W +: W].
REQ-008 req_ready  output  N_REQ  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high at a clk edge.
REQ-009 full  input  1  FIFO write-side full flag (registered, gray-synchronised inside the FIFO).
REQ-010 push  output  1  FIFO write enable.
REQ-011 wdata  output  W  FIFO write data.
REQ-012 grant_id  output  2  index of the currently granted requester; meaningful only while busy=1.
REQ-013 busy  output  1  high while a grant is held (state BUSY).

Function
REQ-014 The block SHALL use two states: IDLE and BUSY.
REQ-015 In IDLE with any req_valid high, it SHALL select the first valid requester in order last+1, last+2, last+3, last (mod 4), register it into grant_id and last, clear the burst counter, and enter BUSY on the next edge.
REQ-016 In IDLE with no req_valid high, it SHALL remain in IDLE.
REQ-017 In IDLE, push and all req_ready bits SHALL be 0.
REQ-018 In BUSY, req_ready[grant_id] SHALL equal ~full, and all other req_ready bits SHALL be 0 (combinational).
REQ-019 In BUSY, push SHALL equal req_valid[grant_id] & ~full, and wdata SHALL equal req_data slice grant_id (combinational, zero latency).
REQ-020 In IDLE, wdata SHALL be 0.
REQ-021 Each push SHALL increment the burst counter (4 bits).
REQ-022 BUSY SHALL go to IDLE at the edge where the BURST-th push of the grant occurs.
REQ-023 BUSY SHALL go to IDLE at any edge where req_valid[grant_id] is 0; a deasserting requester forfeits the grant.
REQ-024 While full=1 with req_valid[grant_id]=1, the block SHALL hold the grant, counter, and state unchanged, with no timeout.
REQ-025 Every change of grant SHALL therefore include exactly one IDLE bubble cycle, and throughput per grant SHALL be BURST pushes per BURST+1 cycles when the FIFO is not full.
REQ-026 push SHALL never be asserted while full=1.
REQ-027 At most one req_ready bit SHALL be high in any cycle.
REQ-028 Any requester continuously valid SHALL be granted within 3 further grants (starvation-free).

Reset
REQ-029 While rst is high, the block SHALL hold state=IDLE, grant_id=0, last=3 (so requester 0 wins first), burst counter=0, busy=0, push=0, req_ready=0, and wdata=0.
REQ-030 rst asserted mid-burst SHALL abort the grant immediately (asynchronously), with no push in the reset cycle.
REQ-031 After rst deasserts, the block SHALL resume arbitration on the first clk edge.

Verification
REQ-032 Single requester: req_valid=0001, full=0, data 0x10..0x17 -> IDLE, 4 pushes (0x10-0x13), 1 IDLE, 4 pushes (0x14-0x17); grant_id=0 throughout.
REQ-033 All valid: req_valid=1111 from reset -> grant order 0,1,2,3,0; each grant gives 4 pushes; busy low 1 cycle between grants.
REQ-034 Full stall: grant to requester 2, full=1 for 5 cycles after the 2nd push -> push=0 and req_ready=0000 during the stall; grant held; exactly 2 more pushes after full drops, then release.
REQ-035 Early drop: requester 1 granted, valid drops after 2 pushes while requester 3 is valid -> IDLE next, then grant_id=3.
REQ-036 Reset mid-burst: rst pulsed after the 1st push of requester 1 -> outputs 0 immediately; after release with req_valid=1010, requester 1 is granted first (last=3).
REQ-037 Random: random valid and full over 10k cycles -> scoreboard per-requester ordering intact, no push while full, onehot0 req_ready, starvation bound met.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one of four requesters access to a FIFO
// write port for up to BURST pushes, with one idle cycle between grants.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               full,
  output logic               push,
  output logic [W-1:0]       wdata,
  output logic [1:0]         grant_id,
  output logic               busy
);

  localparam int unsigned GW = 2;
  localparam int unsigned CW = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_n;
  logic [GW-1:0]   grant_n;
  logic [GW-1:0]   last, last_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [GW-1:0]   sel_c;
  logic [GW-1:0]   idx_c;
  logic            sel_vld_c;
  logic [W-1:0]    slice [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign slice[g] = req_data[g*W +: W];
  end

  // Rotating priority: scan last+4 (=last) down to last+1 so the nearest wins.
  always_comb begin
    sel_c     = last;
    sel_vld_c = 1'b0;
    idx_c     = last;
    for (int i = int'(N_REQ); i >= 1; i--) begin
      idx_c = last + GW'(i);
      if (req_valid[idx_c]) begin
        sel_c     = idx_c;
        sel_vld_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      last     <= GW'(N_REQ - 1);
      cnt      <= '0;
    end else begin
      state    <= state_n;
      grant_id <= grant_n;
      last     <= last_n;
      cnt      <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant_id;
    last_n    = last;
    cnt_n     = cnt;
    push      = 1'b0;
    req_ready = '0;
    wdata     = '0;
    case (state)
      IDLE: begin
        if (sel_vld_c) begin
          grant_n = sel_c;
          last_n  = sel_c;
          cnt_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        req_ready[grant_id] = ~full;
        wdata               = slice[grant_id];
        push                = req_valid[grant_id] & ~full;
        // A dropped valid forfeits the grant; full with valid simply stalls.
        if (!req_valid[grant_id]) begin
          state_n = IDLE;
        end else if (push) begin
          cnt_n = cnt + CW'(1);
          if (cnt_n == CW'(BURST)) state_n = IDLE;
        end
      end
    endcase
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed bursts with hand-computed
// push timing/data, then a random phase checking ordering and fairness.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_data;
  logic              full = 1'b0;
  logic              push;
  logic [DW-1:0]     wdata;
  logic [1:0]        grant_id;
  logic              busy;

  typedef struct {
    int         cyc;
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          random_mode = 1'b0;
  int          seq [NR] = '{0, 0, 0, 0};
  logic [7:0]  base [NR] = '{8'h10, 8'h30, 8'h50, 8'h70};
  int          wait_cnt [NR] = '{0, 0, 0, 0};
  logic        busy_q = 1'b0;
  logic [NR-1:0] xfer_q = '0;
  logic [7:0]  exp_d;
  int          c;

  always #5 clk = ~clk;

  // Each requester presents base + number of words it has already transferred.
  for (genvar g = 0; g < NR; g++) begin : g_data
    assign req_data[g*DW +: DW] = base[g] + 8'(seq[g]);
  end

  fifo_wr_arbiter #(.N_REQ(NR), .W(DW), .BURST(BL)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .push      (push),
    .wdata     (wdata),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always begin
    @(negedge clk);
    xfer_q = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(NR); i++) if (xfer_q[i]) seq[i]++;
  end

  // Monitor: invariants every cycle, scoreboard pop on every push.
  always @(negedge clk) begin
    cyc++;
    checks++;
    if (push && full) begin
      errors++;
      $display("FAIL push_while_full: push=%0b full=%0b cyc=%0d", push, full, cyc);
    end
    checks++;
    if (!$onehot0(req_ready)) begin
      errors++;
      $display("FAIL ready_onehot0: req_ready=%b expected at most one bit cyc=%0d", req_ready, cyc);
    end
    if (push) begin
      checks++;
      if (random_mode) begin
        exp_d = base[grant_id] + 8'(seq[grant_id]);
        if (wdata !== exp_d) begin
          errors++;
          $display("FAIL rand_order: got data=%02h expected %02h (req %0d) cyc=%0d", wdata, exp_d, grant_id, cyc);
        end
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got push id=%0d data=%02h expected no push cyc=%0d", grant_id, wdata, cyc);
      end else begin
        m_e = exp_q.pop_front();
        if (cyc != m_e.cyc || grant_id !== m_e.id || wdata !== m_e.data) begin
          errors++;
          $display("FAIL sb_push: got cyc=%0d id=%0d data=%02h expected cyc=%0d id=%0d data=%02h",
                   cyc, grant_id, wdata, m_e.cyc, m_e.id, m_e.data);
        end
      end
    end
    if (random_mode) begin
      for (int i = 0; i < int'(NR); i++) if (!req_valid[i]) wait_cnt[i] = 0;
      if (busy && !busy_q) begin
        for (int i = 0; i < int'(NR); i++) begin
          if (2'(i) == grant_id) begin
            wait_cnt[i] = 0;
          end else if (req_valid[i]) begin
            wait_cnt[i]++;
            checks++;
            if (wait_cnt[i] > 3) begin
              errors++;
              $display("FAIL starvation: req %0d waited %0d grants expected <= 3 cyc=%0d", i, wait_cnt[i], cyc);
            end
          end
        end
      end
    end
    busy_q = busy;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_burst(input int c0, input logic [1:0] id, input logic [7:0] d0, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back('{c0 + k, id, d0 + 8'(k)});
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pushes outstanding expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_busy"},  32'(busy), 32'd0);
    chk({nm, "_push"},  32'(push), 32'd0);
    chk({nm, "_ready"}, 32'(req_ready), 32'd0);
    chk({nm, "_wdata"}, 32'(wdata), 32'd0);
  endtask

  initial begin
    step(2);
    chk_reset_outputs("rst");
    chk("rst_grant", 32'(grant_id), 32'd0);

    // Single requester: two bursts of 4 separated by one idle cycle.
    rst = 1'b0;
    req_valid = 4'b0001;
    c = cyc;
    exp_burst(c + 2, 2'd0, 8'h10, 4);
    exp_burst(c + 7, 2'd0, 8'h14, 4);
    step(10);
    req_valid = '0;
    drain("single");

    // All valid from reset: grant order 0,1,2,3,0.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    req_valid = 4'b1111;
    c = cyc;
    exp_burst(c + 2,  2'd0, 8'h18, 4);
    exp_burst(c + 7,  2'd1, 8'h30, 4);
    exp_burst(c + 12, 2'd2, 8'h50, 4);
    exp_burst(c + 17, 2'd3, 8'h70, 4);
    exp_burst(c + 22, 2'd0, 8'h1C, 4);
    step(25);
    req_valid = '0;
    drain("all_valid");

    // Full stall after the 2nd push of requester 2.
    req_valid = 4'b0100;
    c = cyc;
    exp_burst(c + 2, 2'd2, 8'h54, 2);
    exp_burst(c + 9, 2'd2, 8'h56, 2);
    step(3);
    full = 1'b1;
    step(2);
    chk("stall_ready", 32'(req_ready), 32'd0);
    chk("stall_push",  32'(push), 32'd0);
    chk("stall_busy",  32'(busy), 32'd1);
    chk("stall_grant", 32'(grant_id), 32'd2);
    step(3);
    full = 1'b0;
    step(2);
    req_valid = '0;
    step(1);
    chk("stall_release", 32'(busy), 32'd0);
    drain("stall");

    // Early drop: requester 1 forfeits after 2 pushes, requester 3 follows.
    req_valid = 4'b0010;
    c = cyc;
    exp_burst(c + 2, 2'd1, 8'h34, 2);
    exp_burst(c + 6, 2'd3, 8'h74, 4);
    step(1);
    req_valid = 4'b1010;
    step(2);
    req_valid = 4'b1000;
    step(1);
    chk("drop_bubble", 32'(busy), 32'd0);
    step(1);
    chk("drop_busy",  32'(busy), 32'd1);
    chk("drop_grant", 32'(grant_id), 32'd3);
    step(4);
    req_valid = '0;
    drain("drop");

    // Reset mid-burst after the first push of requester 1.
    req_valid = 4'b0010;
    c = cyc;
    exp_burst(c + 2, 2'd1, 8'h36, 1);
    step(2);
    chk("mid_pre_push", 32'(push), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    step(2);
    rst = 1'b0;
    req_valid = 4'b1010;
    c = cyc;
    exp_burst(c + 2, 2'd1, 8'h37, 4);
    exp_burst(c + 7, 2'd3, 8'h78, 4);
    step(10);
    req_valid = '0;
    drain("mid_rst");

    // Random valid/full traffic.
    random_mode = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < int'(NR); i++)
        req_valid[i] = req_valid[i] ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
      full = ($urandom_range(0, 3) == 0);
      step(1);
    end
    req_valid = '0;
    full = 1'b0;
    step(BL + 3);
    chk("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
